sram_lsu_master: RTL and testbench
==================================

Name: sram_lsu_master

Overview:
- Initiator-side controller for the byte-writable 32-bit synchronous SRAM macro used for instruction and data memory (14-bit word address, active-low per-byte write enables, chip select, output enable).
- Accepts byte, half and word load/store requests from the CPU's memory stage over a valid/ready handshake and drives the SRAM pins.
- Extracts and sign- or zero-extends read data, flags misaligned accesses, and returns one response per request.

Parameters:
- ADDR_W, 14, SRAM word-address width; the byte address uses bits [ADDR_W+1:2].
- DATA_W, 32, data width; fixed at 32, with 4 byte lanes.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts response.
- rsp_rdata  output  32  extended load data; 0 for stores and errors.
- rsp_err  output  1  misaligned or illegal-size request.
- sram_cs  output  1  SRAM chip select, active high.
- sram_oe  output  1  SRAM output enable, active high.
- sram_web  output  4  SRAM byte write enables, active low; bit i is lane i (bits [8i+7:8i]).
- sram_a  output  ADDR_W  SRAM word address.
- sram_di  output  32  SRAM write data.
- sram_do  input  32  SRAM read data, valid combinationally while cs=1 and oe=1.

Behaviour:
- Reset: asynchronous and active-high. State goes to IDLE immediately. Reset values: rsp_valid=0, rsp_err=0, rsp_rdata=0, sram_cs=0, sram_oe=0, sram_web=4'hF, sram_a=0, sram_di=0. req_ready=1 once rst deasserts.
- The FSM has three states: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid & req_ready, register we, size, unsigned, addr and wdata.
  - An illegal request is size 11, half with addr[0]=1, or word with addr[1:0]!=0. Illegal requests go to RESP with rsp_err=1 and rsp_rdata=0; no SRAM pin toggles.
  - Legal requests go to ACCESS.
- ACCESS (exactly 1 cycle):
  - req_ready=0, sram_cs=1, sram_a=addr[ADDR_W+1:2]. Address bits above ADDR_W+1 are ignored (aliasing).
  - Store: sram_oe=0.
    - sram_web: byte = all-ones with bit addr[1:0] cleared; half = 4'b1100 if addr[1]=0, else 4'b0011; word = 4'b0000.
    - sram_di: byte = wdata[7:0] replicated on all 4 lanes; half = wdata[15:0] replicated on both halves; word = wdata.
    - The write commits at the rising edge ending ACCESS.
  - Load: sram_oe=1, sram_web=4'hF, sram_di=0.
    - At the edge ending ACCESS, select the lane(s) of sram_do indicated by addr[1:0], extend per unsigned to 32 bits, and register into rsp_rdata.
  - Next state is RESP.
- RESP:
  - req_ready=0, rsp_valid=1. SRAM pins return to their idle values (cs=0, oe=0, web=F, a=0, di=0).
  - rsp_rdata and rsp_err hold stable while rsp_ready=0.
  - On rsp_ready=1, go to IDLE. rsp_valid, rsp_err and rsp_rdata clear at that edge.
- Latency: request accept edge → ACCESS → RESP. Minimum 3 cycles per transaction; no overlap between transactions.
- Stores return rsp_rdata=0, rsp_err=0.
- Reset mid-ACCESS: sram_cs and sram_web deassert asynchronously. Whether that write lands is undefined. No response is issued.
- Reset mid-RESP: the pending response is dropped.
- req_valid while not IDLE is ignored; the requester must hold it until req_ready.

Test Plan:
- SW addr 0x10, wdata 0xDEADBEEF → ACCESS cycle shows cs=1, oe=0, a=4, web=4'b0000, di=0xDEADBEEF. Next cycle rsp_valid=1, err=0, rdata=0.
- Following the SW, SB addr 0x13, wdata 0x000000A5 → web=4'b0111, di=0xA5A5A5A5. Then LW 0x10 returns 0xA5ADBEEF with oe=1, web=4'hF.
- Loads at addr 0x13/0x12 after the SB:
  - LB 0x13 → 0xFFFFFFA5; LBU 0x13 → 0x000000A5.
  - LH 0x12 → 0xFFFFA5AD; LHU 0x12 → 0x0000A5AD.
  - SH 0x12, wdata 0x1234 → web=4'b0011, di=0x12341234; then LW 0x10 → 0x1234BEEF.
- LH addr 0x11, LW addr 0x12, size=11 → sram_cs never asserts, rsp_err=1, rdata=0. A following LW 0x10 is unchanged.
- LW with rsp_ready held low 3 cycles → rsp_valid/rdata stable and req_ready=0 throughout. Response retires on the rsp_ready edge; req_ready=1 the next cycle.
- Assert rst during ACCESS of a load → cs=0 and web=F immediately, rsp_valid stays 0, FSM in IDLE with req_ready=1 after release.

Source files
------------

// File: rtl/sram_lsu_master_if.sv
// Bundles the CPU request/response handshake and the SRAM pins for sram_lsu_master.
// The master modport is the controller's view. The slave modport is the view of
// the requester/SRAM side.
interface sram_lsu_master_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [31:0]       req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              sram_cs;
    logic              sram_oe;
    logic [3:0]        sram_web;
    logic [ADDR_W-1:0] sram_a;
    logic [DATA_W-1:0] sram_di;
    logic [DATA_W-1:0] sram_do;

    modport master (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        input  rsp_ready,
        output sram_cs, sram_oe, sram_web, sram_a, sram_di,
        input  sram_do
    );

    modport slave (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        output rsp_ready,
        input  sram_cs, sram_oe, sram_web, sram_a, sram_di,
        output sram_do
    );
endinterface

// File: rtl/sram_lsu_master.sv
// Load/store controller for a byte-writable 32-bit synchronous SRAM.
// Each request takes one SRAM access cycle and returns exactly one response.
// Misaligned requests and illegal sizes are answered with an error and do not touch the SRAM.
module sram_lsu_master #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    sram_lsu_master_if.master bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            r_state;
    logic              r_we;
    logic [1:0]        r_size;
    logic              r_unsigned;
    logic [1:0]        r_addr_lo;
    logic              r_rsp_valid;
    logic              r_rsp_err;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_sram_cs;
    logic              r_sram_oe;
    logic [3:0]        r_sram_web;
    logic [ADDR_W-1:0] r_sram_a;
    logic [DATA_W-1:0] r_sram_di;

    logic              w_illegal;
    logic [3:0]        w_web;
    logic [DATA_W-1:0] w_di;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [DATA_W-1:0] w_load;
    logic              w_unused_addr;

    // Address bits above the SRAM word address alias onto the same word.
    assign w_unused_addr = ^bus.req_addr[31:ADDR_W+2];

    // Legality check, and byte-lane formatting of store data, for the incoming request.
    always_comb begin
        w_illegal = 1'b0;
        w_web     = 4'hF;
        w_di      = bus.req_wdata;
        case (bus.req_size)
            2'b00: begin
                w_web = ~(4'b0001 << bus.req_addr[1:0]);
                w_di  = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                w_illegal = bus.req_addr[0];
                w_web     = bus.req_addr[1] ? 4'b0011 : 4'b1100;
                w_di      = {2{bus.req_wdata[15:0]}};
            end
            2'b10: begin
                w_illegal = (bus.req_addr[1:0] != 2'b00);
                w_web     = 4'b0000;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    // Lane selection and sign/zero extension of SRAM read data during ACCESS.
    always_comb begin
        case (r_addr_lo)
            2'd0:    w_byte = bus.sram_do[7:0];
            2'd1:    w_byte = bus.sram_do[15:8];
            2'd2:    w_byte = bus.sram_do[23:16];
            default: w_byte = bus.sram_do[31:24];
        endcase
        w_half = r_addr_lo[1] ? bus.sram_do[31:16] : bus.sram_do[15:0];
        case (r_size)
            2'b00:   w_load = {{24{~r_unsigned & w_byte[7]}}, w_byte};
            2'b01:   w_load = {{16{~r_unsigned & w_half[15]}}, w_half};
            default: w_load = bus.sram_do;
        endcase
    end

    // Control FSM with registered SRAM pins and response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_we        <= 1'b0;
            r_size      <= 2'b00;
            r_unsigned  <= 1'b0;
            r_addr_lo   <= 2'b00;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
            r_sram_cs   <= 1'b0;
            r_sram_oe   <= 1'b0;
            r_sram_web  <= 4'hF;
            r_sram_a    <= '0;
            r_sram_di   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_we       <= bus.req_we;
                        r_size     <= bus.req_size;
                        r_unsigned <= bus.req_unsigned;
                        r_addr_lo  <= bus.req_addr[1:0];
                        if (w_illegal) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= '0;
                            r_state     <= RESP;
                        end else begin
                            r_sram_cs  <= 1'b1;
                            r_sram_a   <= bus.req_addr[ADDR_W+1:2];
                            r_sram_oe  <= ~bus.req_we;
                            r_sram_web <= bus.req_we ? w_web : 4'hF;
                            r_sram_di  <= bus.req_we ? w_di : '0;
                            r_state    <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    r_sram_cs   <= 1'b0;
                    r_sram_oe   <= 1'b0;
                    r_sram_web  <= 4'hF;
                    r_sram_a    <= '0;
                    r_sram_di   <= '0;
                    r_rsp_valid <= 1'b1;
                    r_rsp_err   <= 1'b0;
                    r_rsp_rdata <= r_we ? '0 : w_load;
                    r_state     <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= '0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = (r_state == IDLE);
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.sram_cs   = r_sram_cs;
    assign bus.sram_oe   = r_sram_oe;
    assign bus.sram_web  = r_sram_web;
    assign bus.sram_a    = r_sram_a;
    assign bus.sram_di   = r_sram_di;
endmodule

// File: tb/tb_sram_lsu_master.sv
// Directed bench for sram_lsu_master with a behavioural SRAM and an expected-response queue.
module tb_sram_lsu_master;
    localparam int ADDR_W = 14;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb_q[$];

    logic [31:0] mem [0:(1<<ADDR_W)-1];

    sram_lsu_master_if #(.ADDR_W(ADDR_W), .DATA_W(32)) bus ();

    sram_lsu_master #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SRAM: combinational read while selected and enabled, byte-masked write on the clock edge.
    assign bus.sram_do = (bus.sram_cs && bus.sram_oe) ? mem[bus.sram_a] : 32'h0;
    always @(posedge clk) begin
        if (bus.sram_cs && !bus.sram_oe) begin
            for (int i = 0; i < 4; i++)
                if (!bus.sram_web[i]) mem[bus.sram_a][8*i +: 8] <= bus.sram_di[8*i +: 8];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete transaction. Pin checks apply during ACCESS for legal requests.
    // After the response has been held for 'hold' cycles, it is popped from the queue and checked.
    task automatic txn(input string name, input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err,
                       input logic [3:0] exp_web, input logic [31:0] exp_di, input int hold);
        int   waited;
        exp_t e;
        logic [31:0] held;
        waited = 0;
        @(negedge clk);
        while (!bus.req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check({name, ":req_ready_wait"}, {31'b0, bus.req_ready}, 32'd1);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        sb_q.push_back('{rdata: exp_rdata, err: exp_err});
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        if (!exp_err) begin
            check({name, ":cs"},  {31'b0, bus.sram_cs}, 32'd1);
            check({name, ":oe"},  {31'b0, bus.sram_oe}, {31'b0, ~we});
            check({name, ":a"},   {18'b0, bus.sram_a}, {18'b0, addr[ADDR_W+1:2]});
            check({name, ":web"}, {28'b0, bus.sram_web}, {28'b0, exp_web});
            check({name, ":di"},  bus.sram_di, exp_di);
            check({name, ":rdy_access"}, {31'b0, bus.req_ready}, 32'd0);
            @(posedge clk); #1;
        end
        check({name, ":cs_in_resp"}, {31'b0, bus.sram_cs}, 32'd0);
        check({name, ":rsp_valid"}, {31'b0, bus.rsp_valid}, 32'd1);
        held = bus.rsp_rdata;
        for (int c = 0; c < hold; c++) begin
            @(posedge clk); #1;
            check({name, ":hold_valid"}, {31'b0, bus.rsp_valid}, 32'd1);
            check({name, ":hold_rdata"}, bus.rsp_rdata, held);
            check({name, ":hold_rdy"}, {31'b0, bus.req_ready}, 32'd0);
        end
        e = sb_q.pop_front();
        check({name, ":rdata"}, bus.rsp_rdata, e.rdata);
        check({name, ":err"}, {31'b0, bus.rsp_err}, {31'b0, e.err});
        $display("txn %s we=%0b size=%0d addr=%h rdata=%h err=%0b", name, we, size, addr,
                 bus.rsp_rdata, bus.rsp_err);
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        check({name, ":rsp_cleared"}, {31'b0, bus.rsp_valid}, 32'd0);
        check({name, ":rdy_after"}, {31'b0, bus.req_ready}, 32'd1);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'h0;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h0;
        bus.req_wdata    = 32'h0;
        bus.rsp_ready    = 1'b0;
        rst = 1'b1;
        #1;
        check("rst:rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        check("rst:rsp_err",   {31'b0, bus.rsp_err}, 32'd0);
        check("rst:rsp_rdata", bus.rsp_rdata, 32'h0);
        check("rst:cs",        {31'b0, bus.sram_cs}, 32'd0);
        check("rst:oe",        {31'b0, bus.sram_oe}, 32'd0);
        check("rst:web",       {28'b0, bus.sram_web}, 32'hF);
        check("rst:a",         {18'b0, bus.sram_a}, 32'h0);
        check("rst:di",        bus.sram_di, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst:req_ready", {31'b0, bus.req_ready}, 32'd1);

        //   name     we  sz    uns  addr          wdata         rdata         err  web      di            hold
        txn("SW10",  1, 2'b10, 0, 32'h10,       32'hDEADBEEF, 32'h0,        0, 4'b0000, 32'hDEADBEEF, 0);
        txn("SB13",  1, 2'b00, 0, 32'h13,       32'h000000A5, 32'h0,        0, 4'b0111, 32'hA5A5A5A5, 0);
        txn("LW10",  0, 2'b10, 0, 32'h10,       32'h0,        32'hA5ADBEEF, 0, 4'hF,    32'h0,        0);
        txn("LB13",  0, 2'b00, 0, 32'h13,       32'h0,        32'hFFFFFFA5, 0, 4'hF,    32'h0,        0);
        txn("LBU13", 0, 2'b00, 1, 32'h13,       32'h0,        32'h000000A5, 0, 4'hF,    32'h0,        0);
        txn("LH12",  0, 2'b01, 0, 32'h12,       32'h0,        32'hFFFFA5AD, 0, 4'hF,    32'h0,        0);
        txn("LHU12", 0, 2'b01, 1, 32'h12,       32'h0,        32'h0000A5AD, 0, 4'hF,    32'h0,        0);
        txn("LB10",  0, 2'b00, 0, 32'h10,       32'h0,        32'hFFFFFFEF, 0, 4'hF,    32'h0,        0);
        txn("LBU11", 0, 2'b00, 1, 32'h11,       32'h0,        32'h000000BE, 0, 4'hF,    32'h0,        0);
        txn("LH10",  0, 2'b01, 0, 32'h10,       32'h0,        32'hFFFFBEEF, 0, 4'hF,    32'h0,        0);
        txn("SH12",  1, 2'b01, 0, 32'h12,       32'h00001234, 32'h0,        0, 4'b0011, 32'h12341234, 0);
        txn("LW10b", 0, 2'b10, 0, 32'h10,       32'h0,        32'h1234BEEF, 0, 4'hF,    32'h0,        0);
        txn("LH11",  0, 2'b01, 0, 32'h11,       32'h0,        32'h0,        1, 4'hF,    32'h0,        0);
        txn("LW12",  0, 2'b10, 0, 32'h12,       32'h0,        32'h0,        1, 4'hF,    32'h0,        0);
        txn("SZ11",  1, 2'b11, 0, 32'h10,       32'hFFFFFFFF, 32'h0,        1, 4'hF,    32'h0,        0);
        txn("LWhold",0, 2'b10, 0, 32'h10,       32'h0,        32'h1234BEEF, 0, 4'hF,    32'h0,        3);
        txn("SB20",  1, 2'b00, 0, 32'h20,       32'h0000117E, 32'h0,        0, 4'b1110, 32'h7E7E7E7E, 0);
        txn("LWalias",0,2'b10, 0, 32'h10010,    32'h0,        32'h1234BEEF, 0, 4'hF,    32'h0,        0);
        txn("LW20",  0, 2'b10, 0, 32'h20,       32'h0,        32'h0000007E, 0, 4'hF,    32'h0,        1);

        // Reset during the ACCESS cycle of a load: pins drop at once and no response follows.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_size  = 2'b10;
        bus.req_addr  = 32'h10;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        check("rstmid:cs_before", {31'b0, bus.sram_cs}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("rstmid:cs",  {31'b0, bus.sram_cs}, 32'd0);
        check("rstmid:web", {28'b0, bus.sram_web}, 32'hF);
        check("rstmid:oe",  {31'b0, bus.sram_oe}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rstmid:rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        check("rstmid:req_ready", {31'b0, bus.req_ready}, 32'd1);
        @(posedge clk); #1;
        check("rstmid:rsp_valid2", {31'b0, bus.rsp_valid}, 32'd0);
        $display("txn RSTMID load reset during ACCESS, rsp_valid=%0b req_ready=%0b",
                 bus.rsp_valid, bus.req_ready);
        check("sb:empty", sb_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
